load_store_unit: RTL and testbench

Sits between the core's execute stage and the combined instruction/data memory. Turns byte-addressed load/store requests (byte, halfword, word; signed/unsigned loads) into whole-word accesses on the memory's word-indexed port pair. Sub-word stores use a read-modify-write sequence because the memory writes only full words. Each request produces exactly one response, carrying load data and an error flag.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-wide memory.
// Byte and halfword stores are done as read-modify-write because the memory
// can only write whole words.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined, misaligned
// halfword and word requests are flagged as errors. When it is not defined,
// they are force-aligned.
//
// state | meaning
// IDLE  | req_ready high; latch the request and decode it
// LOAD  | read the word, then register the formatted load data
// MERGE | read the word, then splice the store bytes into the write buffer
// WRITE | write the buffered word
// RESP  | response held until resp_ready
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_raddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;

  logic        out_of_range;
  logic        misaligned;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Memory strobes and handshakes come straight from the state register, so
  // an asynchronous reset removes them at once, without waiting for an edge.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_ren    = (state == LOAD) || (state == MERGE);
  assign mem_wen    = (state == WRITE);

  // Classify the incoming request.
  always_comb begin
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_U);
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_err = (req_size == 2'd3) || out_of_range || misaligned;
  end

  // Pick the addressed lane from the memory word and extend it for a load.
  // A halfword uses only lane bit 1 and a word uses no lane bits, which gives
  // force-alignment when the check is disabled.
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_data = 32'h0;
    case (lane_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
      2'd1:    load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
      2'd2:    load_data = mem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // Splice the store data into the word that was read back.
  always_comb begin
    merge_data = mem_rdata;
    if (size_q == 2'd0) begin
      case (lane_q)
        2'd0:    merge_data[7:0]   = wdata_q[7:0];
        2'd1:    merge_data[15:8]  = wdata_q[7:0];
        2'd2:    merge_data[23:16] = wdata_q[7:0];
        default: merge_data[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merge_data[31:16] = wdata_q;
    end else begin
      merge_data[15:0] = wdata_q;
    end
  end

  // Sequencer. Address and write-data registers change only when a memory
  // access is being set up, so they keep their last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_waddr  <= 16'h0;
      mem_raddr  <= 16'h0;
      mem_wdata  <= 32'h0;
      lane_q     <= 2'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q     <= req_addr[1:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else if (!req_we) begin
              mem_raddr <= req_addr[17:2];
              state     <= LOAD;
            end else if (req_size == 2'd2) begin
              mem_waddr <= req_addr[17:2];
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              mem_raddr <= req_addr[17:2];
              mem_waddr <= req_addr[17:2];
              state     <= MERGE;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          state      <= RESP;
        end
        MERGE: begin
          mem_wdata <= merge_data;
          state     <= WRITE;
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random requests,
// all checked against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wen, mem_ren;
  logic [15:0] mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int checks   = 0;
  int failures = 0;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_ren && mem_raddr < 16'd256) ? mem[mem_raddr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wen && mem_waddr < 16'd256) mem[mem_waddr[7:0]] <= mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Issue one request, check it against the model, optionally stall the
  // response for 'stall' cycles, then take it.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, output logic [31:0] got);
    logic [31:0] idx, word, v, m, sh, exp_rd, exp_word;
    logic        exp_err;
    int          lat, exp_lat;
    logic [15:0] ren_tr, wen_tr, exp_ren, exp_wen;

    idx = addr / 4;
    exp_err = (size == 2'd3) || (idx >= 256) ||
              (ALIGN && (((size == 2'd1) && (addr % 2 != 0)) ||
                         ((size == 2'd2) && (addr % 4 != 0))));
    exp_rd = 0; exp_word = 0; exp_ren = 0; exp_wen = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else begin
      word = ref_mem[idx[7:0]];
      if (size == 2'd0) begin
        m = 32'hFF;   sh = 8 * (addr % 4);
      end else begin
        m = 32'hFFFF; sh = 16 * ((addr / 2) % 2);
      end
      if (!we) begin
        exp_lat = 2; exp_ren = 16'b010;
        if (size == 2'd2) begin
          exp_rd = word;
        end else begin
          v = (word >> sh) & m;
          if (!uns && v > (m >> 1)) v = v + ~m;
          exp_rd = v;
        end
      end else begin
        if (size == 2'd2) begin
          exp_word = wdata;
          exp_lat = 2; exp_wen = 16'b010;
        end else begin
          exp_word = (word & ~(m << sh)) | ((wdata & m) << sh);
          exp_lat = 3; exp_ren = 16'b010; exp_wen = 16'b100;
        end
        ref_mem[idx[7:0]] = exp_word;
      end
    end

    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check_val("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; ren_tr = 0; wen_tr = 0;
    while (!resp_valid && lat < 12) begin
      ren_tr[lat] = mem_ren;
      wen_tr[lat] = mem_wen;
      if (mem_ren) check_val("mem_raddr", mem_raddr, idx[15:0]);
      if (mem_wen) begin
        check_val("mem_waddr", mem_waddr, idx[15:0]);
        check_val("mem_wdata", mem_wdata, exp_word);
      end
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, exp_lat);
    check_val("ren_cycles", ren_tr, exp_ren);
    check_val("wen_cycles", wen_tr, exp_wen);
    check_val("resp_rdata", resp_rdata, exp_rd);
    check_val("resp_err", resp_err, exp_err);
    got = resp_rdata;

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val("stall_valid", {resp_valid, req_ready, mem_ren, mem_wen}, 4'b1000);
      check_val("stall_rdata", resp_rdata, exp_rd);
      check_val("stall_err", resp_err, exp_err);
    end

    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val("ready_after_resp", {req_ready, resp_valid}, 2'b10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val(tag, {req_ready, resp_valid, resp_err, mem_wen, mem_ren}, 5'b10000);
    check_val({tag, "_rdata"}, resp_rdata, 0);
    check_val({tag, "_addr"}, {mem_waddr, mem_raddr}, 0);
    check_val({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, addr;
    logic [1:0]  size;
    int          r, diffs;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load of the same word.
    run_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, got);
    run_req(0, 2'd2, 0, 32'h10, 32'h0, 0, got);
    check_val("load_deadbeef", got, 32'hDEADBEEF);

    // Byte store through read-modify-write.
    run_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0, got);
    run_req(1, 2'd0, 0, 32'h12, 32'h000000AB, 0, got);
    check_val("mem4_after_byte", mem[4], 32'h11AB3344);

    // Sign and zero extension.
    run_req(1, 2'd2, 0, 32'h14, 32'h8000F0FF, 0, got);
    run_req(0, 2'd0, 0, 32'h14, 32'h0, 0, got);
    check_val("lb_signed", got, 32'hFFFFFFFF);
    run_req(0, 2'd1, 1, 32'h16, 32'h0, 0, got);
    check_val("lhu", got, 32'h00008000);
    run_req(0, 2'd1, 0, 32'h16, 32'h0, 0, got);
    check_val("lh_signed", got, 32'hFFFF8000);

    // Error cases.
    run_req(0, 2'd2, 0, 32'h400, 32'h0, 0, got);
    run_req(0, 2'd3, 0, 32'h20, 32'h0, 0, got);
    run_req(1, 2'd3, 0, 32'h20, 32'h55, 0, got);
    run_req(0, 2'd2, 0, 32'h13, 32'h0, 0, got);
    run_req(1, 2'd1, 0, 32'h15, 32'hCAFE, 0, got);

    // Stalled response.
    run_req(0, 2'd2, 0, 32'h14, 32'h0, 5, got);

    // Reset during WRITE.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("write_before_reset", mem_wen, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_write");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("word8_untouched", mem[8], ref_mem[8]);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      addr = (r == 0) ? $urandom : $urandom_range(0, 1023);
      r = $urandom_range(0, 9);
      size = (r == 0) ? 2'd3 : 2'(r % 3);
      run_req(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
              $urandom, $urandom_range(0, 2), got);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check_val("final_mem_diffs", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
